// File: rtl/load_unit.sv
// Load unit: accepts one lw/lh/lhu/lb/lbu request, issues a word-aligned read to a
// variable-latency memory port and returns the lane-extracted, extended result.
module load_unit #(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned TO_W    = 5
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ld_valid,
   output logic        ld_ready,
   input  logic [2:0]  ld_type,
   input  logic [31:0] ld_addr,
   output logic        mem_re,
   output logic [31:0] mem_addr,
   input  logic [31:0] mem_rdata,
   input  logic        mem_rvalid,
   output logic        rd_valid,
   output logic [31:0] rd_data,
   output logic        rd_err
);

   typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

   localparam logic [2:0] TyLw  = 3'b000;
   localparam logic [2:0] TyLh  = 3'b001;
   localparam logic [2:0] TyLhu = 3'b010;
   localparam logic [2:0] TyLb  = 3'b011;
   localparam logic [2:0] TyLbu = 3'b100;

   state_e            state_q, state_d;
   logic [2:0]        type_q, type_d;
   logic [1:0]        off_q, off_d;
   logic [31:0]       mem_addr_q, mem_addr_d;
   logic [TO_W-1:0]   cnt_q, cnt_d;
   logic [31:0]       rd_data_q, rd_data_d;
   logic              rd_err_q, rd_err_d;

   logic              bad_req;
   logic [15:0]       half_sel;
   logic [7:0]        byte_sel;
   logic [31:0]       ext_data;

   // Request screening happens on the raw inputs so errors skip the memory entirely.
   always_comb begin
      bad_req = 1'b0;
      unique case (ld_type)
         TyLw:        bad_req = (ld_addr[1:0] != 2'b00);
         TyLh, TyLhu: bad_req = ld_addr[0];
         TyLb, TyLbu: bad_req = 1'b0;
         default:     bad_req = 1'b1;
      endcase
   end

   always_comb begin
      half_sel = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      byte_sel = mem_rdata[7:0];
      unique case (off_q)
         2'd0: byte_sel = mem_rdata[7:0];
         2'd1: byte_sel = mem_rdata[15:8];
         2'd2: byte_sel = mem_rdata[23:16];
         2'd3: byte_sel = mem_rdata[31:24];
         default: byte_sel = mem_rdata[7:0];
      endcase
      ext_data = '0;
      unique case (type_q)
         TyLw:    ext_data = mem_rdata;
         TyLh:    ext_data = {{16{half_sel[15]}}, half_sel};
         TyLhu:   ext_data = {16'h0000, half_sel};
         TyLb:    ext_data = {{24{byte_sel[7]}}, byte_sel};
         TyLbu:   ext_data = {24'h000000, byte_sel};
         default: ext_data = '0;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      type_d     = type_q;
      off_d      = off_q;
      mem_addr_d = mem_addr_q;
      cnt_d      = cnt_q;
      rd_data_d  = rd_data_q;
      rd_err_d   = rd_err_q;
      unique case (state_q)
         StIdle: begin
            if (ld_valid) begin
               type_d     = ld_type;
               off_d      = ld_addr[1:0];
               mem_addr_d = {ld_addr[31:2], 2'b00};
               if (bad_req) begin
                  rd_data_d = '0;
                  rd_err_d  = 1'b1;
                  state_d   = StResp;
               end else begin
                  state_d = StReq;
               end
            end
         end
         StReq: begin
            cnt_d   = '0;
            state_d = StWait;
         end
         StWait: begin
            // rvalid wins over a timeout landing in the same cycle.
            if (mem_rvalid) begin
               rd_data_d = ext_data;
               rd_err_d  = 1'b0;
               state_d   = StResp;
            end else if (cnt_q == TO_W'(TIMEOUT - 1)) begin
               rd_data_d = '0;
               rd_err_d  = 1'b1;
               state_d   = StResp;
            end else begin
               cnt_d = cnt_q + TO_W'(1);
            end
         end
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         type_q     <= 3'b000;
         off_q      <= 2'b00;
         mem_addr_q <= '0;
         cnt_q      <= '0;
         rd_data_q  <= '0;
         rd_err_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         type_q     <= type_d;
         off_q      <= off_d;
         mem_addr_q <= mem_addr_d;
         cnt_q      <= cnt_d;
         rd_data_q  <= rd_data_d;
         rd_err_q   <= rd_err_d;
      end
   end

   assign ld_ready = (state_q == StIdle);
   assign mem_re   = (state_q == StReq);
   assign rd_valid = (state_q == StResp);
   assign mem_addr = mem_addr_q;
   assign rd_data  = rd_data_q;
   assign rd_err   = rd_err_q;

endmodule

// File: tb/tb_load_unit.sv
// Directed bench for load_unit: table of load vectors with hand-computed results,
// plus sequences for stray responses and reset during an outstanding read.
module tb_load_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        ld_valid;
   logic        ld_ready;
   logic [2:0]  ld_type;
   logic [31:0] ld_addr;
   logic        mem_re;
   logic [31:0] mem_addr;
   logic [31:0] mem_rdata;
   logic        mem_rvalid;
   logic        rd_valid;
   logic [31:0] rd_data;
   logic        rd_err;

   int n_checks = 0;
   int n_fail   = 0;

   load_unit #(.TIMEOUT(16), .TO_W(5)) dut (
      .clk        (clk),
      .reset      (reset),
      .ld_valid   (ld_valid),
      .ld_ready   (ld_ready),
      .ld_type    (ld_type),
      .ld_addr    (ld_addr),
      .mem_re     (mem_re),
      .mem_addr   (mem_addr),
      .mem_rdata  (mem_rdata),
      .mem_rvalid (mem_rvalid),
      .rd_valid   (rd_valid),
      .rd_data    (rd_data),
      .rd_err     (rd_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  ty;
      logic [31:0] addr;
      logic [31:0] rdata;
      int          dly;       // cycle after acceptance carrying rvalid; 0 = never
      logic [31:0] exp_data;
      logic        exp_err;
      int          exp_lat;   // cycles from acceptance to rd_valid
      int          exp_re;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic add(input logic [2:0] ty, input logic [31:0] addr, input logic [31:0] rdata,
                      input int dly, input logic [31:0] ed, input logic ee, input int lat,
                      input int re);
      vec_t v;
      v.ty = ty; v.addr = addr; v.rdata = rdata; v.dly = dly;
      v.exp_data = ed; v.exp_err = ee; v.exp_lat = lat; v.exp_re = re;
      vecs.push_back(v);
   endtask

   task automatic run(input vec_t v);
      bit got;
      int lat, re_cnt, busy_rdy;
      got = 0; lat = 0; re_cnt = 0; busy_rdy = 0;
      @(negedge clk);
      chk("ready_before", 32'(ld_ready), 32'd1);
      ld_valid = 1'b1; ld_type = v.ty; ld_addr = v.addr;
      @(negedge clk);
      ld_valid = 1'b0;
      for (int k = 1; k <= 40 && !got; k++) begin
         if (mem_re) begin
            re_cnt++;
            chk("mem_addr", mem_addr, {v.addr[31:2], 2'b00});
         end
         if (ld_ready) busy_rdy++;
         if (rd_valid) begin
            got = 1; lat = k;
            mem_rvalid = 1'b0;
         end else begin
            mem_rdata  = v.rdata;
            mem_rvalid = (v.dly != 0 && k == v.dly);
            @(negedge clk);
         end
      end
      mem_rvalid = 1'b0;
      chk("rd_valid_seen", 32'(got), 32'd1);
      chk("latency", 32'(lat), 32'(v.exp_lat));
      chk("rd_data", rd_data, v.exp_data);
      chk("rd_err", 32'(rd_err), 32'(v.exp_err));
      chk("mem_re_count", 32'(re_cnt), 32'(v.exp_re));
      chk("ready_while_busy", 32'(busy_rdy), 32'd0);
      @(negedge clk);
      chk("rd_valid_pulse", 32'(rd_valid), 32'd0);
      chk("ready_after", 32'(ld_ready), 32'd1);
      chk("rd_data_held", rd_data, v.exp_data);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; ld_valid = 1'b0; ld_type = 3'b000; ld_addr = '0;
      mem_rdata = '0; mem_rvalid = 1'b0;

      //   type    addr          rdata         dly ed            ee lat re
      add(3'b000, 32'h10, 32'hDEADBEEF, 2, 32'hDEADBEEF, 0, 3, 1);
      add(3'b011, 32'h13, 32'h80112233, 2, 32'hFFFFFF80, 0, 3, 1);
      add(3'b100, 32'h13, 32'h80112233, 2, 32'h00000080, 0, 3, 1);
      add(3'b100, 32'h10, 32'h80112233, 2, 32'h00000033, 0, 3, 1);
      add(3'b011, 32'h11, 32'h80112233, 2, 32'h00000022, 0, 3, 1);
      add(3'b001, 32'h12, 32'h8001FFFF, 2, 32'hFFFF8001, 0, 3, 1);
      add(3'b010, 32'h12, 32'h8001FFFF, 2, 32'h00008001, 0, 3, 1);
      add(3'b001, 32'h10, 32'h8001FFFF, 2, 32'hFFFFFFFF, 0, 3, 1);
      add(3'b010, 32'h10, 32'h8001FFFF, 2, 32'h0000FFFF, 0, 3, 1);
      add(3'b000, 32'h11, 32'h12345678, 0, 32'h00000000, 1, 1, 0);
      add(3'b000, 32'h24, 32'hCAFEF00D, 5, 32'hCAFEF00D, 0, 6, 1);
      add(3'b001, 32'h13, 32'h12345678, 0, 32'h00000000, 1, 1, 0);
      add(3'b100, 32'h22, 32'h00AB0000, 4, 32'h000000AB, 0, 5, 1);
      add(3'b010, 32'h11, 32'h12345678, 0, 32'h00000000, 1, 1, 0);
      add(3'b111, 32'h20, 32'h12345678, 0, 32'h00000000, 1, 1, 0);
      add(3'b101, 32'h20, 32'h12345678, 0, 32'h00000000, 1, 1, 0);
      add(3'b000, 32'h30, 32'h11111111, 0, 32'h00000000, 1, 18, 1);

      repeat (2) @(negedge clk);
      chk("reset_ready", 32'(ld_ready), 32'd1);
      chk("reset_mem_re", 32'(mem_re), 32'd0);
      chk("reset_mem_addr", mem_addr, 32'd0);
      chk("reset_rd_valid", 32'(rd_valid), 32'd0);
      chk("reset_rd_data", rd_data, 32'd0);
      chk("reset_rd_err", 32'(rd_err), 32'd0);
      reset = 1'b0;

      foreach (vecs[i]) run(vecs[i]);

      // Stray rvalid after the timeout must be dropped.
      for (int i = 0; i < 3; i++) begin
         mem_rdata = 32'h55555555; mem_rvalid = 1'b1;
         @(negedge clk);
         chk("stray_rd_valid", 32'(rd_valid), 32'd0);
         chk("stray_rd_data", rd_data, 32'd0);
      end
      mem_rvalid = 1'b0;
      run(vecs[0]);

      // Reset while waiting on memory abandons the read.
      @(negedge clk);
      ld_valid = 1'b1; ld_type = 3'b000; ld_addr = 32'h40;
      @(negedge clk);
      ld_valid = 1'b0;
      chk("rst_seq_mem_re", 32'(mem_re), 32'd1);
      @(negedge clk);
      chk("rst_seq_busy", 32'(ld_ready), 32'd0);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("rst_wait_ready", 32'(ld_ready), 32'd1);
      chk("rst_wait_mem_re", 32'(mem_re), 32'd0);
      chk("rst_wait_mem_addr", mem_addr, 32'd0);
      chk("rst_wait_rd_valid", 32'(rd_valid), 32'd0);
      chk("rst_wait_rd_data", rd_data, 32'd0);
      chk("rst_wait_rd_err", 32'(rd_err), 32'd0);
      mem_rdata = 32'h99999999; mem_rvalid = 1'b1;
      @(negedge clk);
      mem_rvalid = 1'b0;
      chk("rst_late_rd_valid", 32'(rd_valid), 32'd0);
      run(vecs[5]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
